// File: rtl/score_draw_scheduler.sv
// Per-frame HUD score renderer: snapshots distance digits and high-score characters
// at frame start, then streams one glyph request per visible character to the blitter.
module score_draw_scheduler #(
   parameter int MAX_DISTANCE_UNITS   = 5,
   parameter int MAX_HIGH_SCORE_UNITS = 8,
   parameter int DEST_WIDTH           = 11,
   parameter int X                    = 1148,
   parameter int HIGH_SCORE_X         = 948,
   parameter int Y                    = 20
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  frame_start,
   input  logic [MAX_DISTANCE_UNITS-1:0][3:0]    digits,
   input  logic [MAX_HIGH_SCORE_UNITS-1:0][3:0]  high_score,
   input  logic                                  paint,
   input  logic                                  show_high_score,
   output logic                                  blit_req,
   input  logic                                  blit_ack,
   output logic [3:0]                            blit_glyph,
   output logic [10:0]                           blit_x,
   output logic [9:0]                            blit_y,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  overrun
);

   localparam int TOTAL_ITEMS = MAX_DISTANCE_UNITS + MAX_HIGH_SCORE_UNITS;
   localparam int CW          = $clog2(TOTAL_ITEMS + 1);

   localparam logic [CW-1:0] LP_DCOUNT = CW'(MAX_DISTANCE_UNITS);
   localparam logic [CW-1:0] LP_HCOUNT = CW'(MAX_HIGH_SCORE_UNITS);
   localparam logic [10:0]   LP_STEP   = 11'(DEST_WIDTH * 2);
   localparam logic [10:0]   LP_X      = 11'(X);
   localparam logic [10:0]   LP_HX     = 11'(HIGH_SCORE_X);
   localparam logic [9:0]    LP_Y      = 10'(Y);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [MAX_DISTANCE_UNITS-1:0][3:0]   r_digits;
   logic [MAX_HIGH_SCORE_UNITS-1:0][3:0] r_highScore;
   logic                                 r_paint;
   logic [CW-1:0]                        r_count;
   logic [CW-1:0]                        r_idx;
   logic                                 r_overrun;

   logic          w_accept;
   logic          w_ackTaken;
   logic          w_last;
   logic [CW-1:0] w_newCount;
   logic          w_isDigit;
   logic [CW-1:0] w_pos;
   logic [3:0]    w_glyph;
   logic [10:0]   w_x;

   assign w_accept   = frame_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_ackTaken = (r_state == S_ISSUE) && blit_ack;
   assign w_last     = (r_idx == (r_count - CW'(1)));
   assign w_newCount = (paint ? LP_DCOUNT : '0) + (show_high_score ? LP_HCOUNT : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               w_next = (w_newCount != '0) ? S_ISSUE : S_DONE;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (blit_ack) begin
               w_next = w_last ? S_DONE : S_GAP;
            end
         end
         S_GAP: begin
            w_next = S_ISSUE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // The snapshot is only taken on an accepted frame start, so mid-frame input changes stay invisible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digits    <= '0;
         r_highScore <= '0;
         r_paint     <= 1'b0;
         r_count     <= '0;
         r_idx       <= '0;
      end else if (w_accept) begin
         r_digits    <= digits;
         r_highScore <= high_score;
         r_paint     <= paint;
         r_count     <= w_newCount;
         r_idx       <= '0;
      end else if (w_ackTaken && !w_last) begin
         r_idx <= r_idx + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (frame_start && ((r_state == S_ISSUE) || (r_state == S_GAP))) begin
         r_overrun <= 1'b1;
      end
   end

   // Items are packed: distance digits first (when painted), then high-score characters.
   always_comb begin
      w_isDigit = r_paint && (r_idx < LP_DCOUNT);
      w_pos     = (w_isDigit || !r_paint) ? r_idx : (r_idx - LP_DCOUNT);
      w_glyph   = '0;
      if (w_isDigit) begin
         for (int i = 0; i < MAX_DISTANCE_UNITS; i++) begin
            if (w_pos == CW'(i)) begin
               w_glyph = r_digits[i];
            end
         end
      end else begin
         for (int j = 0; j < MAX_HIGH_SCORE_UNITS; j++) begin
            if (w_pos == CW'(j)) begin
               w_glyph = r_highScore[j];
            end
         end
      end
      w_x = (w_isDigit ? LP_X : LP_HX) + (LP_STEP * 11'(w_pos));
   end

   always_comb begin
      blit_req   = 1'b0;
      blit_glyph = '0;
      blit_x     = '0;
      blit_y     = '0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_ISSUE: begin
            blit_req   = 1'b1;
            blit_glyph = w_glyph;
            blit_x     = w_x;
            blit_y     = LP_Y;
            busy       = 1'b1;
         end
         S_GAP: begin
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            blit_req = 1'b0;
         end
      endcase
   end

   assign overrun = r_overrun;

endmodule

// File: tb/tb_score_draw_scheduler.sv
// Directed-vector bench for score_draw_scheduler: each task drives one scenario and
// checks outputs cycle by cycle against hand-computed values.
module tb_score_draw_scheduler;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             frame_start;
   logic [4:0][3:0]  digits;
   logic [7:0][3:0]  high_score;
   logic             paint;
   logic             show_high_score;
   logic             blit_req;
   logic             blit_ack;
   logic [3:0]       blit_glyph;
   logic [10:0]      blit_x;
   logic [9:0]       blit_y;
   logic             busy;
   logic             done;
   logic             overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   score_draw_scheduler dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .frame_start     (frame_start),
      .digits          (digits),
      .high_score      (high_score),
      .paint           (paint),
      .show_high_score (show_high_score),
      .blit_req        (blit_req),
      .blit_ack        (blit_ack),
      .blit_glyph      (blit_glyph),
      .blit_x          (blit_x),
      .blit_y          (blit_y),
      .busy            (busy),
      .done            (done),
      .overrun         (overrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_hi_row();
      high_score    = '0;
      high_score[0] = 4'd10;
      high_score[1] = 4'd11;
      high_score[2] = 4'd12;
      high_score[5] = 4'd5;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_start = 1'b0; blit_ack = 1'b0;
      paint = 1'b0; show_high_score = 1'b0; digits = '0; high_score = '0;
      #3;
      total++;
      if ({blit_req, busy, done, overrun} !== 4'b0000) begin
         bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {blit_req, busy, done, overrun});
      end
      total++;
      if ({blit_glyph, blit_x, blit_y} !== 25'd0) begin
         bad++; $display("[TB] FAIL reset_data got=%0h want=0", {blit_glyph, blit_x, blit_y});
      end
      rst_n = 1'b1;
      step();
      for (int k = 0; k < 5; k++) digits[k] = 4'(7 - k);
      paint = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      total++;
      if (blit_req !== 1'b1 || blit_glyph !== 4'd7) begin
         bad++; $display("[TB] FAIL reset_first_req got=%b/%0d want=1/7", blit_req, blit_glyph);
      end
      blit_ack = 1'b1;
      repeat (12) step();
      blit_ack = 1'b0;
   endtask

   task automatic test_full_frame();
      int expG[13] = '{0, 1, 2, 3, 4, 10, 11, 12, 0, 0, 5, 0, 0};
      int expX[13] = '{1148, 1170, 1192, 1214, 1236, 948, 970, 992, 1014, 1036, 1058, 1080, 1102};
      int k;
      for (int i = 0; i < 5; i++) digits[i] = 4'(i);
      load_hi_row();
      paint = 1'b1; show_high_score = 1'b1; blit_ack = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         if ((c % 2 == 1) && c <= 25) begin
            k = (c - 1) / 2;
            total++;
            if (blit_req !== 1'b1 || blit_glyph !== 4'(expG[k]) || blit_x !== 11'(expX[k]) || blit_y !== 10'd20) begin
               bad++; $display("[TB] FAIL full_item k=%0d got req=%b g=%0d x=%0d y=%0d want 1/%0d/%0d/20",
                               k, blit_req, blit_glyph, blit_x, blit_y, expG[k], expX[k]);
            end
         end else if (c == 26) begin
            total++;
            if (done !== 1'b1 || blit_req !== 1'b0) begin
               bad++; $display("[TB] FAIL full_done c=%0d got done=%b req=%b want 1/0", c, done, blit_req);
            end
         end else begin
            total++;
            if (blit_req !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
               bad++; $display("[TB] FAIL full_gap c=%0d got req=%b busy=%b done=%b want 0/1/0", c, blit_req, busy, done);
            end
         end
         if (c != 26) step();
      end
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL full_idle got done=%b busy=%b want 0/0", done, busy);
      end
      blit_ack = 1'b0;
   endtask

   task automatic test_flash();
      int expG[8] = '{10, 11, 12, 0, 0, 5, 0, 0};
      int k;
      load_hi_row();
      paint = 1'b0; show_high_score = 1'b1; blit_ack = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if ((c % 2 == 1) && c <= 15) begin
            k = (c - 1) / 2;
            total++;
            if (blit_req !== 1'b1 || blit_glyph !== 4'(expG[k]) || blit_x !== 11'(948 + 22 * k)) begin
               bad++; $display("[TB] FAIL flash_item k=%0d got req=%b g=%0d x=%0d want 1/%0d/%0d",
                               k, blit_req, blit_glyph, blit_x, expG[k], 948 + 22 * k);
            end
         end else if (c == 16) begin
            total++;
            if (done !== 1'b1 || blit_req !== 1'b0) begin
               bad++; $display("[TB] FAIL flash_done got done=%b req=%b want 1/0", done, blit_req);
            end
         end else begin
            total++;
            if (blit_req !== 1'b0) begin
               bad++; $display("[TB] FAIL flash_gap c=%0d got req=%b want 0", c, blit_req);
            end
         end
         if (c != 16) step();
      end
      step();
      blit_ack = 1'b0;
   endtask

   task automatic test_empty();
      paint = 1'b0; show_high_score = 1'b0; blit_ack = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      total++;
      if (done !== 1'b1 || blit_req !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL empty_done got done=%b req=%b busy=%b want 1/0/0", done, blit_req, busy);
      end
      step();
      total++;
      if (done !== 1'b0 || blit_req !== 1'b0) begin
         bad++; $display("[TB] FAIL empty_idle got done=%b req=%b want 0/0", done, blit_req);
      end
      blit_ack = 1'b0;
   endtask

   task automatic test_backpressure();
      int expItem[15] = '{0, -1, 1, -1, 2, 2, 2, 2, 2, 2, -1, 3, -1, 4, -1};
      int it;
      for (int i = 0; i < 5; i++) digits[i] = 4'(i + 5);
      paint = 1'b1; show_high_score = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         blit_ack = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
         it = expItem[c - 1];
         if (it >= 0) begin
            total++;
            if (blit_req !== 1'b1 || blit_glyph !== 4'(it + 5) || blit_x !== 11'(1148 + 22 * it) || blit_y !== 10'd20) begin
               bad++; $display("[TB] FAIL bp_item c=%0d got req=%b g=%0d x=%0d y=%0d want 1/%0d/%0d/20",
                               c, blit_req, blit_glyph, blit_x, blit_y, it + 5, 1148 + 22 * it);
            end
         end else if (c == 15) begin
            total++;
            if (done !== 1'b1 || blit_req !== 1'b0) begin
               bad++; $display("[TB] FAIL bp_done got done=%b req=%b want 1/0", done, blit_req);
            end
         end else begin
            total++;
            if (blit_req !== 1'b0 || done !== 1'b0) begin
               bad++; $display("[TB] FAIL bp_gap c=%0d got req=%b done=%b want 0/0", c, blit_req, done);
            end
         end
         if (c == 3) digits = '0;
         if (c != 15) step();
      end
      step();
      blit_ack = 1'b0;
   endtask

   task automatic test_overrun();
      int reqCount = 0;
      for (int i = 0; i < 5; i++) digits[i] = 4'(9 - i);
      paint = 1'b1; show_high_score = 1'b0; blit_ack = 1'b1;
      total++;
      if (overrun !== 1'b0) begin
         bad++; $display("[TB] FAIL ovr_initial got=%b want=0", overrun);
      end
      frame_start = 1'b1;
      step();
      for (int c = 1; c <= 20; c++) begin
         frame_start = (c == 2) ? 1'b1 : 1'b0;
         if (blit_req === 1'b1) reqCount++;
         if (c == 10) begin
            total++;
            if (done !== 1'b1) begin
               bad++; $display("[TB] FAIL ovr_done got=%b want=1", done);
            end
         end
         step();
      end
      frame_start = 1'b0;
      total++;
      if (reqCount != 5) begin
         bad++; $display("[TB] FAIL ovr_req_count got=%0d want=5", reqCount);
      end
      total++;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("[TB] FAIL ovr_sticky got overrun=%b busy=%b want 1/0", overrun, busy);
      end
      blit_ack = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) digits[i] = 4'(i + 2);
      paint = 1'b1; show_high_score = 1'b0; blit_ack = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      rst_n = 1'b0;
      #2;
      total++;
      if (blit_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("[TB] FAIL arst_drop got req=%b busy=%b ovr=%b want 0/0/0", blit_req, busy, overrun);
      end
      #1;
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 5; i++) digits[i] = 4'(i + 3);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      total++;
      if (blit_req !== 1'b1 || blit_glyph !== 4'd3 || blit_x !== 11'd1148) begin
         bad++; $display("[TB] FAIL arst_restart got req=%b g=%0d x=%0d want 1/3/1148", blit_req, blit_glyph, blit_x);
      end
      blit_ack = 1'b1;
      repeat (10) step();
      blit_ack = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("[TB] FAIL arst_finish got busy=%b want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_flash();
      test_empty();
      test_backpressure();
      test_overrun();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_draw_scheduler.md
# score_draw_scheduler

Sequences per-frame rendering of the distance meter: on each frame start it snapshots the live distance digits, high-score characters and flash/visibility controls, then issues one glyph-draw request per visible character to the shared sprite blitter over a req/ack handshake. It sits between `distance_meter` and the single glyph blitter that the HUD shares. Its snapshot keeps a frame's score rendering coherent while the meter updates mid-frame.

## Interface
Parameters:
- `MAX_DISTANCE_UNITS`, 5: distance digit count.
- `MAX_HIGH_SCORE_UNITS`, 8: high-score chars, including 3 "HI" glyphs (codes 10–12).
- `DEST_WIDTH`, 11: glyph pitch; on-screen step is `DEST_WIDTH*2` = 22 px.
- `X`, 1148: x of distance digit 0.
- `HIGH_SCORE_X`, 948: x of high-score char 0.
- `Y`, 20: y of every glyph.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `frame_start`, in, 1: one-cycle pulse at start of vblank.
- `digits`, in, 5×4: distance digits; index 0 is the most significant.
- `high_score`, in, 8×4: high-score chars; index 0 is leftmost.
- `paint`, in, 1: distance digits visible (low during achievement flash).
- `show_high_score`, in, 1: high-score row visible.
- `blit_req`, out, 1: draw request.
- `blit_ack`, in, 1: blitter accepts the request in this cycle.
- `blit_glyph`, out, 4: glyph code.
- `blit_x`, out, 11: destination x.
- `blit_y`, out, 10: destination y.
- `busy`, out, 1: a draw sequence is in progress.
- `done`, out, 1: one-cycle pulse when the sequence completes.
- `overrun`, out, 1: sticky; set when a `frame_start` is dropped.

## Operation
- States are IDLE, ISSUE, GAP and DONE.
- IDLE or DONE with `frame_start`=1:
  - Snapshot `digits`, `high_score`, `paint` and `show_high_score` into registers.
  - Build the item list: distance digits 0..4 if snapshot `paint`=1, then high-score chars 0..7 if snapshot `show_high_score`=1.
  - Item count is 0..13.
  - Go to ISSUE if the count is nonzero, otherwise go to DONE.
- ISSUE:
  - `blit_req`=1.
  - `blit_glyph`, `blit_x` and `blit_y` come from the current item and stay stable while `blit_req` is high.
  - On `blit_ack`=1: go to DONE if this is the last item, otherwise advance the item index and go to GAP.
  - With `blit_ack`=0, hold the request indefinitely.
- GAP: `blit_req`=0 for one cycle, then ISSUE.
- DONE: `done`=1 for one cycle, then IDLE (unless a new `frame_start` is accepted).
- Coordinates:
  - Distance digit i: `blit_x` = X + 22·i.
  - High-score char j: `blit_x` = HIGH_SCORE_X + 22·j.
  - `blit_y` = Y for every item.
  - All arithmetic is unsigned, sized to 11 bits; no overflow is possible with the default parameters.
- A `frame_start` in ISSUE or GAP is ignored and sets `overrun`. The sequence in progress finishes using its own snapshot.
- `overrun` clears only on reset.
- Input changes after the snapshot have no effect until the next accepted `frame_start`.
- `blit_ack` while `blit_req`=0 is ignored.
- `busy`=1 exactly in ISSUE and GAP.

## Timing
- Reset values: `blit_req`, `blit_glyph`, `blit_x`, `blit_y`, `busy`, `done` and `overrun` are all 0; state is IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-sequence drops `blit_req` immediately, without completing the handshake.
- `frame_start` sampled at edge t gives the first `blit_req` in cycle t+1, with `busy` high from t+1.
- Handshake completes at the edge where `blit_req` and `blit_ack` are both 1.
- With `blit_ack` tied high, item k is requested in cycle t+1+2k.
  - Full 13-item frame: last ack in cycle t+25, `done` in cycle t+26.
- An empty list (`paint`=0, `show_high_score`=0) gives `done` in cycle t+1 with no request.
- Each ack stall of one cycle delays all later items and `done` by one cycle.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs 0. Release, then `frame_start` → `blit_req` high on the next cycle.
- **Full frame:**
  - Stimulus: `digits`={0,1,2,3,4}, `high_score`={10,11,12,0,0,5,0,0}, `paint`=1, `show_high_score`=1, ack tied high.
  - Response: 13 requests.
  - Glyphs 0,1,2,3,4,10,11,12,0,0,5,0,0.
  - x = 1148,1170,1192,1214,1236, then 948,970,…,1102.
  - y = 20 throughout; `done` in cycle t+26.
- **Flash:** `paint`=0, `show_high_score`=1 → only the 8 high-score requests. Both 0 → `done` at t+1 with no `blit_req`.
- **Backpressure:** `blit_ack` low for 5 cycles on item 2 → item 2's glyph/x/y held stable, `done` delayed by 5 cycles. Changing `digits` mid-frame does not alter the issued glyphs.
- **Overrun:** `frame_start` during GAP → `overrun`=1 and remains 1. The current sequence still issues exactly its item count, and no second sequence starts.
- **Async reset mid-ISSUE:** `blit_req` and `busy` drop within the reset cycle. After release and a new `frame_start`, the sequence restarts at item 0.
